// File: rtl/ex_alu_unit.sv
// Execute-stage ALU: single-cycle logic/arith/compare/shift ops with a registered result,
// plus a fixed-latency iterative shift-add multiplier that holds busy_o while it runs.
module ex_alu_unit #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [3:0]         ctrl_i,
  input  logic [DATA_W-1:0]  src1_i,
  input  logic [DATA_W-1:0]  src2_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic [DATA_W-1:0]  result_o,
  output logic               zero_o,
  output logic               valid_o,
  output logic               busy_o
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SRAV = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1011;
  localparam logic [3:0] OP_BNE  = 4'b1100;

  localparam logic [SHAMT_W-1:0] LAST_ITER = {SHAMT_W{1'b1}};

  typedef enum logic [0:0] {IDLE = 1'b0, MUL_RUN = 1'b1} state_t;

  function automatic logic [DATA_W-1:0] alu_result(
    input logic [3:0]         op,
    input logic [DATA_W-1:0]  a,
    input logic [DATA_W-1:0]  b,
    input logic [SHAMT_W-1:0] sh
  );
    logic [DATA_W-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLT:  r = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SRA:  r = $signed(b) >>> sh;
      OP_SRAV: r = $signed(b) >>> a[SHAMT_W-1:0];
      OP_BNE:  r = a - b;
      default: r = {DATA_W{1'b0}};
    endcase
    return r;
  endfunction

  // BNE reports inequality so branch logic can test zero_o the same way for BEQ and BNE
  function automatic logic zero_flag(
    input logic [3:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [DATA_W-1:0] r
  );
    logic z;
    if (op == OP_BNE) begin
      z = (a != b);
    end else begin
      z = (r == {DATA_W{1'b0}});
    end
    return z;
  endfunction

  state_t             state_r;
  logic [DATA_W-1:0]  mcand_r;
  logic [DATA_W-1:0]  mplier_r;
  logic [DATA_W-1:0]  acc_r;
  logic [SHAMT_W-1:0] cnt_r;

  logic [DATA_W-1:0]  alu_res_s;
  logic               alu_zero_s;
  logic [DATA_W-1:0]  acc_next_s;

  // Single-cycle datapath and next multiplier accumulator value
  always_comb begin
    alu_res_s  = alu_result(ctrl_i, src1_i, src2_i, shamt_i);
    alu_zero_s = zero_flag(ctrl_i, src1_i, src2_i, alu_res_s);
    if (mplier_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Control FSM, multiplier iteration and registered outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r  <= IDLE;
      mcand_r  <= {DATA_W{1'b0}};
      mplier_r <= {DATA_W{1'b0}};
      acc_r    <= {DATA_W{1'b0}};
      cnt_r    <= {SHAMT_W{1'b0}};
      result_o <= {DATA_W{1'b0}};
      zero_o   <= 1'b0;
      valid_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_i && (ctrl_i == OP_MUL)) begin
            mcand_r  <= src1_i;
            mplier_r <= src2_i;
            acc_r    <= {DATA_W{1'b0}};
            cnt_r    <= {SHAMT_W{1'b0}};
            busy_o   <= 1'b1;
            state_r  <= MUL_RUN;
          end else if (start_i) begin
            result_o <= alu_res_s;
            zero_o   <= alu_zero_s;
            valid_o  <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        MUL_RUN: begin
          acc_r    <= acc_next_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + {{(SHAMT_W-1){1'b0}}, 1'b1};
          // Final iteration publishes the accumulator including this cycle's partial product
          if (cnt_r == LAST_ITER) begin
            result_o <= acc_next_s;
            zero_o   <= (acc_next_s == {DATA_W{1'b0}});
            valid_o  <= 1'b1;
            busy_o   <= 1'b0;
            state_r  <= IDLE;
          end else begin
            state_r <= MUL_RUN;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_alu_unit.sv
// Scoreboard bench for ex_alu_unit: directed cases from the test plan plus random ops,
// checked against an arithmetic reference model with cycle-accurate latency expectations.
module tb_ex_alu_unit;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [3:0]    ctrl;
  logic [DW-1:0] src1, src2;
  logic [4:0]    shamt;
  logic [DW-1:0] result;
  logic          zero, valid, busy;

  ex_alu_unit #(.DATA_W(DW), .SHAMT_W(5)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .ctrl_i(ctrl),
    .src1_i(src1), .src2_i(src2), .shamt_i(shamt),
    .result_o(result), .zero_o(zero), .valid_o(valid), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] res;
    logic          z;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   mul_start = -1000;

  // Edge counter: after rising edge n, cyc == n
  always @(posedge clk) cyc = cyc + 1;

  function automatic exp_t ref_op(input logic [3:0] op, input logic [DW-1:0] a,
                                  input logic [DW-1:0] b, input logic [4:0] sh);
    exp_t e;
    longint unsigned prod;
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0010: e.res = a + b;
      4'b0110: e.res = a - b;
      4'b0111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: e.res = $signed(b) >>> sh;
      4'b1001: e.res = $signed(b) >>> a[4:0];
      4'b1011: begin
        prod  = longint'(a) * longint'(b);
        e.res = prod[31:0];
      end
      4'b1100: e.res = a - b;
      default: e.res = 32'd0;
    endcase
    e.z   = (op == 4'b1100) ? (a != b) : (e.res == 32'd0);
    e.cyc = 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: busy window, latency and result/zero of every valid pulse
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", {31'd0, busy}, {31'd0, (cyc >= mul_start && cyc < mul_start + 32)});
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("missing_valid", 32'd0, 32'd1);
        void'(exp_q.pop_front());
      end
      if (valid) begin
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", result, e.res);
          check("zero", {31'd0, zero}, {31'd0, e.z});
        end
      end
    end
  end

  // Drive one request at the next edge; the model decides whether it is accepted
  task automatic issue(input logic [3:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [4:0] sh);
    exp_t e;
    int n;
    start = 1'b1; ctrl = op; src1 = a; src2 = b; shamt = sh;
    @(posedge clk); #1;
    n = cyc;
    if (!(n >= mul_start + 1 && n <= mul_start + 32)) begin
      e = ref_op(op, a, b, sh);
      e.cyc = (op == 4'b1011) ? n + 32 : n;
      if (op == 4'b1011) mul_start = n;
      exp_q.push_back(e);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    start = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    mul_start = -1000;
    #1;
    check("rst_result", result, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] ops [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                           4'b1000, 4'b1001, 4'b1011, 4'b1100, 4'b1111};

  initial begin
    int guard;
    rst_n = 1'b0; start = 1'b0; ctrl = 4'd0; src1 = '0; src2 = '0; shamt = '0;
    #1;
    check("init_result", result, 32'd0);
    check("init_zero", {31'd0, zero}, 32'd0);
    check("init_valid", {31'd0, valid}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Reset in the middle of a multiply, then a plain add
    issue(4'b1011, 32'd7, 32'd9, 5'd0);
    idle(9);
    do_reset();
    issue(4'b0010, 32'd1, 32'd2, 5'd0);
    idle(2);

    // Back-to-back single-cycle sweep
    issue(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd0);
    issue(4'b0110, 32'd5, 32'd7, 5'd0);
    issue(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0);
    issue(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 5'd0);
    issue(4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 5'd0);
    idle(1);

    // Shifts
    issue(4'b1000, 32'd0, 32'h8000_0000, 5'd4);
    issue(4'b1001, 32'h0000_0023, 32'h0000_0040, 5'd0);

    // Multiplies
    issue(4'b1011, 32'd12345, 32'd6789, 5'd0);
    idle(32);
    issue(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    idle(32);
    issue(4'b1011, 32'd0, 32'hDEAD_BEEF, 5'd0);
    idle(32);

    // Start while busy is ignored; start in the valid cycle is accepted
    issue(4'b1011, 32'd3, 32'd4, 5'd0);
    idle(4);
    issue(4'b0010, 32'd1, 32'd1, 5'd0);
    idle(27);
    issue(4'b0010, 32'd1, 32'd1, 5'd0);
    idle(1);

    // Branch flag and undefined op
    issue(4'b0110, 32'd9, 32'd9, 5'd0);
    issue(4'b1100, 32'd9, 32'd9, 5'd0);
    issue(4'b1100, 32'd9, 32'd8, 5'd0);
    issue(4'b1111, 32'd9, 32'd8, 5'd0);
    idle(1);

    // Random traffic, including starts that land while a multiply runs
    for (int i = 0; i < 60; i++) begin
      logic [3:0] op;
      op = ops[$urandom_range(0, 9)];
      if (op == 4'b1011 && $urandom_range(0, 2) != 0) op = 4'b0010;
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      issue(op, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, 5'($urandom));
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) check("drain_timeout", 32'd0, 32'd1);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
